pa_dtu_cdc_evt_sched: RTL and testbench

PA_DTU_CDC_EVT_SCHED -- requirements
Module: pa_dtu_cdc_evt_sched

---
 rtl/pa_dtu_cdc_pkg.sv | 27 ++
 rtl/pa_dtu_rr_arb.sv | 41 ++++
 rtl/pa_dtu_cdc_evt_sched.sv | 157 +++++++++++++++
 tb/tb_pa_dtu_cdc_evt_sched.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_dtu_cdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pa_dtu_cdc_pkg
//  Description : Shared types, default parameter constants and helpers for
//                the DTU CDC event scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package pa_dtu_cdc_pkg;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_ID_W        = 2;
    localparam int DEF_TIMEOUT_CYC = 64;

    // Scheduler FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } sched_state_t;

    // Index reached by stepping 'off' places past 'base' in a ring of size n
    function automatic int rr_wrap(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pa_dtu_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : pa_dtu_rr_arb
//  Description : Combinational round-robin arbiter. The search starts one
//                place after the last granted index and wraps to zero.
//                Returns a one-hot grant, its encoded index and a valid flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pa_dtu_rr_arb
    import pa_dtu_cdc_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic [NUM_REQ-1:0] pend,
    input  logic [ID_W-1:0]    last_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_vld
);

    logic [ID_W-1:0] cand;

    // Walk the ring from last_ptr+1; the first pending index wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'(rr_wrap(int'(last_ptr), off, NUM_REQ));
            if (!grant_vld && pend[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_vld   = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pa_dtu_cdc_evt_sched.sv
`default_nettype none
// ============================================================================
//  Module      : pa_dtu_cdc_evt_sched
//  Description : Queues single-cycle events from NUM_REQ source requesters
//                and serialises them, round-robin, onto one pulse-crossing
//                channel. One pulse is in flight at a time; the channel's
//                chan_done strobe releases the scheduler for the next event.
//                Config macro: PA_DTU_CDC_SCHED_TIMEOUT_EN enables the WAIT
//                watchdog (TIMEOUT_CYC) and the sticky timeout_err flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pa_dtu_cdc_evt_sched
    import pa_dtu_cdc_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ID_W        = DEF_ID_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               src_clk,
    input  logic               src_rst_b,
    input  logic [NUM_REQ-1:0] req,
    input  logic               chan_done,
    input  logic               ovf_clr,
    output logic               chan_pulse,
    output logic [ID_W-1:0]    chan_id,
    output logic [NUM_REQ-1:0] pend,
    output logic               busy,
    output logic [NUM_REQ-1:0] ovf,
    output logic               timeout_err
);

    sched_state_t       state;
    sched_state_t       state_nxt;

    logic [NUM_REQ-1:0] pend_nxt;
    logic [NUM_REQ-1:0] ovf_nxt;
    logic [NUM_REQ-1:0] clr_mask;
    logic [ID_W-1:0]    chan_id_nxt;
    logic [ID_W-1:0]    last_ptr;
    logic [ID_W-1:0]    last_ptr_nxt;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_vld;
    logic               timeout_hit;

    pa_dtu_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arb (
        .pend      (pend),
        .last_ptr  (last_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // Outputs decoded purely from the registered state
    assign chan_pulse = (state == ST_SEND);
    assign busy       = (state == ST_SEND) || (state == ST_WAIT);

    // Next-state logic: grant in IDLE, one-cycle SEND, WAIT for the channel
    always_comb begin
        state_nxt    = state;
        chan_id_nxt  = chan_id;
        last_ptr_nxt = last_ptr;
        clr_mask     = '0;
        case (state)
            ST_IDLE: begin
                if (grant_vld) begin
                    clr_mask     = grant;
                    chan_id_nxt  = grant_idx;
                    last_ptr_nxt = grant_idx;
                    state_nxt    = ST_SEND;
                end
            end
            ST_SEND: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (chan_done || timeout_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pending/overflow update: a new request beats a same-cycle grant clear,
    // and a new drop beats a same-cycle ovf_clr
    always_comb begin
        pend_nxt = (pend & ~clr_mask) | req;
        ovf_nxt  = (ovf_clr ? '0 : ovf) | (req & pend & ~clr_mask);
    end

    // FSM state register
    always_ff @(posedge src_clk or negedge src_rst_b) begin
        if (!src_rst_b) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Queue, flag, channel-id and round-robin pointer registers
    always_ff @(posedge src_clk or negedge src_rst_b) begin
        if (!src_rst_b) begin
            pend     <= '0;
            ovf      <= '0;
            chan_id  <= '0;
            last_ptr <= ID_W'(NUM_REQ - 1);
        end else begin
            pend     <= pend_nxt;
            ovf      <= ovf_nxt;
            chan_id  <= chan_id_nxt;
            last_ptr <= last_ptr_nxt;
        end
    end

`ifdef PA_DTU_CDC_SCHED_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMO_W-1:0] tmo_cnt;
    logic             timeout_q;

    assign timeout_hit = (state == ST_WAIT) && !chan_done &&
                         (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign timeout_err = timeout_q;

    // Watchdog: counts WAIT cycles from 0, flag is sticky until reset
    always_ff @(posedge src_clk or negedge src_rst_b) begin
        if (!src_rst_b) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if ((state == ST_WAIT) && !chan_done && !timeout_hit) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = (TIMEOUT_CYC > 0);
    assign timeout_hit    = 1'b0;
    assign timeout_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pa_dtu_cdc_evt_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pa_dtu_cdc_evt_sched
//  Description : Directed self-checking bench for pa_dtu_cdc_evt_sched.
//                Inputs change and outputs are sampled 1 ns after each
//                rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pa_dtu_cdc_evt_sched;

    logic       clk;
    logic       rst_b;
    logic [3:0] req;
    logic       chan_done;
    logic       ovf_clr;
    logic       chan_pulse;
    logic [1:0] chan_id;
    logic [3:0] pend;
    logic       busy;
    logic [3:0] ovf;
    logic       timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    pa_dtu_cdc_evt_sched #(
        .NUM_REQ     (4),
        .ID_W        (2),
        .TIMEOUT_CYC (8)
    ) dut (
        .src_clk     (clk),
        .src_rst_b   (rst_b),
        .req         (req),
        .chan_done   (chan_done),
        .ovf_clr     (ovf_clr),
        .chan_pulse  (chan_pulse),
        .chan_id     (chan_id),
        .pend        (pend),
        .busy        (busy),
        .ovf         (ovf),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        req       = '0;
        chan_done = 1'b0;
        ovf_clr   = 1'b0;
        rst_b     = 1'b0;
        tick();
        tick();
        rst_b = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset();
        n_cmp++;
        if ({chan_pulse, chan_id, pend, busy, ovf, timeout_err} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_state: got pulse=%b id=%0d pend=%b busy=%b ovf=%b to=%b, want all 0",
                     chan_pulse, chan_id, pend, busy, ovf, timeout_err);
        end
    endtask

    // req at cycle 0 -> pulse at cycle 2, busy until chan_done
    task automatic test_single;
        apply_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        n_cmp++;
        if (pend !== 4'b0001 || chan_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL single_c1: got pend=%b pulse=%b, want 0001/0", pend, chan_pulse);
        end
        tick();
        n_cmp++;
        if (chan_pulse !== 1'b1 || chan_id !== 2'd0 || busy !== 1'b1 || pend !== 4'b0000) begin
            n_err++;
            $display("FAIL single_c2: got pulse=%b id=%0d busy=%b pend=%b, want 1/0/1/0000",
                     chan_pulse, chan_id, busy, pend);
        end
        tick();
        n_cmp++;
        if (chan_pulse !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_wait: got pulse=%b busy=%b, want 0/1", chan_pulse, busy);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_hold: got busy=%b, want 1", busy);
        end
        chan_done = 1'b1;
        tick();
        chan_done = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || chan_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle: got busy=%b pulse=%b, want 0/0", busy, chan_pulse);
        end
        // chan_done while IDLE is ignored
        chan_done = 1'b1;
        tick();
        chan_done = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || chan_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL idle_done_ignored: got busy=%b pulse=%b, want 0/0", busy, chan_pulse);
        end
    endtask

    // all four at once, chan_done 3 cycles after each pulse
    task automatic test_round_robin;
        logic [3:0] exp_pend [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
        apply_reset();
        req = 4'b1111;
        tick();
        req = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            int waited = 0;
            while (chan_pulse !== 1'b1 && waited < 10) begin
                tick();
                waited++;
            end
            n_cmp++;
            if (chan_pulse !== 1'b1) begin
                n_err++;
                $display("FAIL rr_pulse_timeout: event %0d got no pulse within 10 cycles", k);
            end
            n_cmp++;
            if (chan_id !== 2'(k) || pend !== exp_pend[k]) begin
                n_err++;
                $display("FAIL rr_order: event %0d got id=%0d pend=%b, want id=%0d pend=%b",
                         k, chan_id, pend, k, exp_pend[k]);
            end
            tick();
            tick();
            tick();
            chan_done = 1'b1;
            tick();
            chan_done = 1'b0;
        end
        tick();
        tick();
        n_cmp++;
        if (pend !== 4'b0000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rr_drain: got pend=%b busy=%b, want 0000/0", pend, busy);
        end
    endtask

    task automatic test_overflow;
        int pulses = 0;
        apply_reset();
        req = 4'b0001;          // occupy the channel with index 0
        tick();
        req = 4'b0000;
        tick();                 // SEND
        req = 4'b0010;
        tick();                 // WAIT, pend[1] set
        n_cmp++;
        if (pend !== 4'b0010 || ovf !== 4'b0000) begin
            n_err++;
            $display("FAIL ovf_queue: got pend=%b ovf=%b, want 0010/0000", pend, ovf);
        end
        tick();                 // second req[1] dropped
        tick();                 // third req[1] dropped
        req = 4'b0000;
        n_cmp++;
        if (ovf !== 4'b0010 || pend !== 4'b0010) begin
            n_err++;
            $display("FAIL ovf_set: got ovf=%b pend=%b, want 0010/0010", ovf, pend);
        end
        ovf_clr = 1'b1;         // clear racing a new drop: drop wins
        req     = 4'b0010;
        tick();
        ovf_clr = 1'b0;
        req     = 4'b0000;
        n_cmp++;
        if (ovf !== 4'b0010) begin
            n_err++;
            $display("FAIL ovf_clr_race: got ovf=%b, want 0010", ovf);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_cmp++;
        if (ovf !== 4'b0000) begin
            n_err++;
            $display("FAIL ovf_clr: got ovf=%b, want 0000", ovf);
        end
        chan_done = 1'b1;
        tick();                 // IDLE, grant 1
        chan_done = 1'b0;
        tick();                 // SEND
        n_cmp++;
        if (chan_pulse !== 1'b1 || chan_id !== 2'd1 || pend !== 4'b0000) begin
            n_err++;
            $display("FAIL ovf_serve: got pulse=%b id=%0d pend=%b, want 1/1/0000",
                     chan_pulse, chan_id, pend);
        end
        tick();
        chan_done = 1'b1;
        tick();
        chan_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (chan_pulse === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL ovf_single_event: got %0d extra pulses, want 0", pulses);
        end
    endtask

    // req[2] on the cycle index 2 is granted; also req while in flight
    task automatic test_same_cycle_grant;
        apply_reset();
        req = 4'b0100;
        tick();                 // pend[2]=1, grant of 2 this cycle
        req = 4'b0100;
        tick();                 // SEND
        req = 4'b0000;
        n_cmp++;
        if (chan_pulse !== 1'b1 || chan_id !== 2'd2 || pend !== 4'b0100 || ovf !== 4'b0000) begin
            n_err++;
            $display("FAIL set_wins: got pulse=%b id=%0d pend=%b ovf=%b, want 1/2/0100/0000",
                     chan_pulse, chan_id, pend, ovf);
        end
        req = 4'b0001;          // queue index 0 while 2 is in flight
        tick();                 // WAIT
        req = 4'b0000;
        tick();
        n_cmp++;
        if (chan_id !== 2'd2 || pend !== 4'b0101) begin
            n_err++;
            $display("FAIL inflight_id: got id=%0d pend=%b, want 2/0101", chan_id, pend);
        end
        chan_done = 1'b1;
        tick();                 // IDLE: search from 3 -> index 0 wins
        chan_done = 1'b0;
        tick();
        n_cmp++;
        if (chan_pulse !== 1'b1 || chan_id !== 2'd0 || pend !== 4'b0100) begin
            n_err++;
            $display("FAIL rr_after2: got pulse=%b id=%0d pend=%b, want 1/0/0100",
                     chan_pulse, chan_id, pend);
        end
        tick();
        chan_done = 1'b1;
        tick();
        chan_done = 1'b0;
        tick();
        n_cmp++;
        if (chan_pulse !== 1'b1 || chan_id !== 2'd2 || pend !== 4'b0000) begin
            n_err++;
            $display("FAIL second_pulse2: got pulse=%b id=%0d pend=%b, want 1/2/0000",
                     chan_pulse, chan_id, pend);
        end
    endtask

    task automatic test_timeout;
        apply_reset();
        req = 4'b0001;
        tick();                 // grant 0
        req = 4'b0010;
        tick();                 // SEND, pend[1] queued
        req = 4'b0000;
        tick();                 // first WAIT cycle (count 0)
        for (int i = 0; i < 7; i++) tick();
        n_cmp++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_before: got busy=%b to=%b, want 1/0", busy, timeout_err);
        end
        tick();
`ifdef PA_DTU_CDC_SCHED_TIMEOUT_EN
        n_cmp++;
        if (busy !== 1'b0 || timeout_err !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_fire: got busy=%b to=%b, want 0/1", busy, timeout_err);
        end
        tick();
        n_cmp++;
        if (chan_pulse !== 1'b1 || chan_id !== 2'd1 || timeout_err !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_next: got pulse=%b id=%0d to=%b, want 1/1/1",
                     chan_pulse, chan_id, timeout_err);
        end
`else
        for (int i = 0; i < 12; i++) tick();
        n_cmp++;
        if (busy !== 1'b1 || timeout_err !== 1'b0 || chan_id !== 2'd0) begin
            n_err++;
            $display("FAIL no_tmo_hold: got busy=%b to=%b id=%0d, want 1/0/0",
                     busy, timeout_err, chan_id);
        end
        chan_done = 1'b1;
        tick();
        chan_done = 1'b0;
        tick();
        n_cmp++;
        if (chan_pulse !== 1'b1 || chan_id !== 2'd1) begin
            n_err++;
            $display("FAIL no_tmo_next: got pulse=%b id=%0d, want 1/1", chan_pulse, chan_id);
        end
`endif
    endtask

    task automatic test_reset_mid_wait;
        int pulses = 0;
        apply_reset();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();                 // SEND id 1
        tick();                 // WAIT
        rst_b = 1'b0;
        #1;
        n_cmp++;
        if ({chan_pulse, chan_id, pend, busy, ovf, timeout_err} !== 13'd0) begin
            n_err++;
            $display("FAIL rst_async: got pulse=%b id=%0d pend=%b busy=%b ovf=%b to=%b, want all 0",
                     chan_pulse, chan_id, pend, busy, ovf, timeout_err);
        end
        tick();
        rst_b = 1'b1;
        tick();
        chan_done = 1'b1;
        tick();
        chan_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (chan_pulse === 1'b1 || busy === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0 || chan_id !== 2'd0 || pend !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_abandon: got %0d active cycles id=%0d pend=%b, want 0/0/0000",
                     pulses, chan_id, pend);
        end
    endtask

    initial begin
        rst_b     = 1'b0;
        req       = '0;
        chan_done = 1'b0;
        ovf_clr   = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_same_cycle_grant();
        test_timeout();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
